// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the 7-segment scan driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned OUT_W      = SEG_W + 1;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef logic [IDX_W-1:0] idx_t;

  // One digit as driven onto the pins: {dp, g..a}.
  typedef struct packed {
    logic             dp;
    logic [SEG_W-1:0] seg;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{dp: 1'b0, seg: SEG_BLANK};

  // One-hot anode enable for a digit index.
  function automatic logic [NUM_DIGITS-1:0] idx_onehot(input idx_t idx);
    idx_onehot = NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler, counts 0..DIV-1 while enabled and
// flags the terminal count. The tick is combinational so the digit index
// advances on the same edge the prescaler wraps.
module scan_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == CNT_LAST);
  assign tick   = en & w_term;

  // Prescaler count; frozen while disabled so scanning resumes mid-slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit 7-segment scanner. Inputs are
// snapshotted once per frame (on the 3->0 index wrap) so a frame never
// shows a mix of old and new characters.
// Optional per-digit blinking is built in when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SEG_W-1:0]      char0,
  input  logic [SEG_W-1:0]      char1,
  input  logic [SEG_W-1:0]      char2,
  input  logic [SEG_W-1:0]      char3,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [OUT_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam idx_t IDX_LAST = idx_t'(NUM_DIGITS - 1);

  logic   w_tick;
  logic   w_wrap;
  logic   w_blank;
  idx_t   r_idx;
  digit_t w_in     [NUM_DIGITS];
  digit_t r_shadow [NUM_DIGITS];
  digit_t w_cur;
  digit_t w_drive;

  scan_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  // Frame boundary: the tick that takes the index from the last digit to 0.
  assign w_wrap = w_tick & (r_idx == IDX_LAST);

  assign w_in[0] = '{dp: dp[0], seg: char0};
  assign w_in[1] = '{dp: dp[1], seg: char1};
  assign w_in[2] = '{dp: dp[2], seg: char2};
  assign w_in[3] = '{dp: dp[3], seg: char3};

  // Digit index advances once per prescaler tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Shadow snapshot of characters and decimal points, taken only at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= DIGIT_BLANK;
      end
    end else if (w_wrap) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= w_in[i];
      end
    end
  end

  // One-cycle pulse following the snapshot edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_wrap;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned       FCNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [FCNT_W-1:0]     r_frame_cnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_blink_sh;

  // Frame counter and blink phase; advanced on the wrap edge that also
  // raises frame_start, so the new phase applies from the first digit of
  // the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      if (r_frame_cnt == FCNT_LAST) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  // Blink request snapshot, captured together with the characters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_sh <= '0;
    end else if (w_wrap) begin
      r_blink_sh <= blink_mask;
    end
  end

  assign w_blank = r_phase & r_blink_sh[r_idx];
`else
  // Blink support not built: port and parameter kept for a stable interface.
  logic w_unused_blink;
  assign w_unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
  assign w_blank        = 1'b0;
`endif

  // Select the current digit, blanking segments and dp when it blinks off.
  always_comb begin
    w_cur   = r_shadow[r_idx];
    w_drive = w_cur;
    if (w_blank) begin
      w_drive = DIGIT_BLANK;
    end
  end

  // Registered pin drive, one cycle behind the index; dark while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      seg_out <= '0;
      an      <= '0;
    end else begin
      seg_out <= w_drive;
      an      <= idx_onehot(r_idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver.
// Main instance uses SCAN_DIV=4, BLINK_FRAMES=2; a second instance uses
// SCAN_DIV=1. Blink expectations follow SEG_BLINK_EN.
module tb_seg_scan_driver;

  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;

`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [6:0] CH_E = 7'b1111001;
  localparam logic [6:0] CH_R = 7'b1010000;
  localparam logic [6:0] CH_F = 7'b1110001;
  localparam logic [6:0] CH_8 = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst, en, rst_f, en_f;
  logic [6:0] char0, char1, char2, char3;
  logic [3:0] dp, blink_mask;
  logic [7:0] seg_out, seg_out_f;
  logic [3:0] an, an_f;
  logic       frame_start, frame_start_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(DIV), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3),
    .dp(dp), .blink_mask(blink_mask),
    .seg_out(seg_out), .an(an), .frame_start(frame_start)
  );

  seg_scan_driver #(.SCAN_DIV(1), .BLINK_FRAMES(BF)) u_fast (
    .clk(clk), .rst(rst_f), .en(en_f),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3),
    .dp(dp), .blink_mask(blink_mask),
    .seg_out(seg_out_f), .an(an_f), .frame_start(frame_start_f)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle of the main instance, sampled on the falling edge.
  task automatic cyc(input string tag, input logic [3:0] ean, input logic [7:0] eseg, input logic efs);
    @(negedge clk);
    chk({tag, ".an"},  {4'b0, an},          {4'b0, ean});
    chk({tag, ".seg"}, seg_out,             eseg);
    chk({tag, ".fs"},  {7'b0, frame_start}, {7'b0, efs});
  endtask

  task automatic slot_run(input string tag, input int slot, input int n, input logic [7:0] eseg, input bit fs_last);
    for (int c = 0; c < n; c++) begin
      cyc($sformatf("%s.d%0d.c%0d", tag, slot, c), 4'(1 << slot), eseg, fs_last && (c == n - 1));
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    slot_run(tag, 0, DIV, s0, 1'b0);
    slot_run(tag, 1, DIV, s1, 1'b0);
    slot_run(tag, 2, DIV, s2, 1'b0);
    slot_run(tag, 3, DIV, s3, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s0;
    logic [7:0] fexp [4];

    rst = 1'b1; en = 1'b0; rst_f = 1'b1; en_f = 1'b0;
    char0 = '0; char1 = '0; char2 = '0; char3 = '0;
    dp = '0; blink_mask = '0;

    // Reset state of both instances.
    cyc("rst0", 4'b0, 8'h00, 1'b0);
    cyc("rst1", 4'b0, 8'h00, 1'b0);
    chk("fast.rst.an", {4'b0, an_f}, 8'h00);
    chk("fast.rst.seg", seg_out_f, 8'h00);

    // F r E E: blank first frame, then the snapshot.
    char3 = CH_F; char2 = CH_R; char1 = CH_E; char0 = CH_E;
    rst = 1'b0; en = 1'b1;
    frame("f1", 8'h00, 8'h00, 8'h00, 8'h00);
    frame("f2", {1'b0, CH_E}, {1'b0, CH_E}, {1'b0, CH_R}, {1'b0, CH_F});

    // Mid-frame char2 change while idx=1 stays hidden until next frame.
    slot_run("f3", 0, DIV, {1'b0, CH_E}, 1'b0);
    char2 = CH_8;
    slot_run("f3", 1, DIV, {1'b0, CH_E}, 1'b0);
    slot_run("f3", 2, DIV, {1'b0, CH_R}, 1'b0);
    slot_run("f3", 3, DIV, {1'b0, CH_F}, 1'b1);
    frame("f4", {1'b0, CH_E}, {1'b0, CH_E}, {1'b0, CH_8}, {1'b0, CH_F});

    // Disable for 10 cycles two cycles into digit 2; resume with remaining count.
    slot_run("f5", 0, DIV, {1'b0, CH_E}, 1'b0);
    slot_run("f5", 1, DIV, {1'b0, CH_E}, 1'b0);
    slot_run("f5", 2, 2,   {1'b0, CH_8}, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("f5.off%0d", i), 4'b0, 8'h00, 1'b0);
    end
    en = 1'b1;
    slot_run("f5r", 2, 2,   {1'b0, CH_8}, 1'b0);
    slot_run("f5r", 3, DIV, {1'b0, CH_F}, 1'b1);

    // Reset one cycle into digit 3: outputs clear, restart blank from idx 0.
    slot_run("f6", 0, DIV, {1'b0, CH_E}, 1'b0);
    slot_run("f6", 1, DIV, {1'b0, CH_E}, 1'b0);
    slot_run("f6", 2, DIV, {1'b0, CH_8}, 1'b0);
    slot_run("f6", 3, 1,   {1'b0, CH_F}, 1'b0);
    rst = 1'b1;
    cyc("f6.rst", 4'b0, 8'h00, 1'b0);
    rst = 1'b0;
    frame("r1", 8'h00, 8'h00, 8'h00, 8'h00);
    frame("r2", {1'b0, CH_E}, {1'b0, CH_E}, {1'b0, CH_8}, {1'b0, CH_F});

    // Blink on digit 0, decimal point on digit 3, counted from a fresh reset.
    dp = 4'b1000; blink_mask = 4'b0001; rst = 1'b1;
    cyc("bk.rst", 4'b0, 8'h00, 1'b0);
    rst = 1'b0;
    frame("bk.f1", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int f = 2; f <= 7; f++) begin
      s0 = (BLINK_ON && (f == 3 || f == 4 || f == 7)) ? 8'h00 : {1'b0, CH_E};
      frame($sformatf("bk.f%0d", f), s0, {1'b0, CH_E}, {1'b0, CH_8}, {1'b1, CH_F});
    end

    // SCAN_DIV=1: index steps every cycle, frame_start every 4 cycles.
    fexp[0] = {1'b0, CH_E}; fexp[1] = {1'b0, CH_E};
    fexp[2] = {1'b0, CH_8}; fexp[3] = {1'b1, CH_F};
    rst_f = 1'b0; en_f = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("fast.f%0d.k%0d.an", f, k), {4'b0, an_f}, {4'b0, 4'(1 << k)});
        chk($sformatf("fast.f%0d.k%0d.fs", f, k), {7'b0, frame_start_f}, {7'b0, (k == 3)});
        if (f == 1) chk($sformatf("fast.f1.k%0d.seg", k), seg_out_f, 8'h00);
        if (f == 2) chk($sformatf("fast.f2.k%0d.seg", k), seg_out_f, fexp[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, 100000, clk cycles per digit slot; SHALL be >= 1.
REQ-002 Parameter BLINK_FRAMES, 250, frames per blink half-period; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  display enable.
REQ-006 char0..char3  input  7 each  segment patterns {g..a}, active-high; char3 is leftmost digit.
REQ-007 dp  input  4  per-digit decimal point, bit i belongs to digit i.
REQ-008 blink_mask  input  4  per-digit blink request.
REQ-009 seg_out  output  8  {dp, g..a}, active-high, registered.
REQ-010 an  output  4  digit enable, one-hot active-high, registered.
REQ-011 frame_start  output  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 while en=1 and issue tick on terminal count.
- SCAN_DIV=1 SHALL give a tick every cycle.
REQ-013 Digit index idx SHALL advance 0->1->2->3->0 on each tick.
REQ-014 On the tick that takes idx 3->0, char0..3, dp and blink_mask SHALL be captured into shadow registers in the same edge.
- Inputs changing mid-frame SHALL NOT appear until the next frame.
REQ-015 frame_start SHALL be 1 for exactly the cycle after the 3->0 capture edge, else 0.
REQ-016 Outputs SHALL be registered one cycle behind idx.
- an = 1<<idx.
- seg_out = {shadow_dp[idx], shadow_char[idx]}.
REQ-017 en=0 SHALL hold prescaler, idx and blink state, and SHALL drive an=0 and seg_out=0 from the next cycle.
- On en 0->1, scanning SHALL resume from the held idx and prescaler count.
REQ-018 Shadow capture SHALL occur only on a 3->0 tick, so no capture occurs while en=0.
REQ-019 When a capture and an input change coincide, the value sampled at that edge SHALL be the one used.

Reset
REQ-020 While rst=1, and on the first cycle after it, the block SHALL hold:
- prescaler=0, idx=0
- shadow registers all 0
- blink phase=0, frame counter=0
- seg_out=0, an=0, frame_start=0
REQ-021 rst SHALL take priority over en and over any pending tick.
REQ-022 Reset mid-frame SHALL discard the partial frame; the first frame after reset SHALL display blanks until the first capture.

Configuration
REQ-023 With SEG_BLINK_EN defined:
- A frame counter SHALL count frame_start pulses.
- Blink phase SHALL toggle every BLINK_FRAMES frames.
- While phase=1, any digit whose shadow blink_mask bit is 1 SHALL output seg_out=0 with its an bit still asserted.
REQ-024 Without SEG_BLINK_EN:
- The blink_mask port SHALL remain but be ignored.
- No frame counter or phase register SHALL be synthesised.
- The display SHALL never blank due to blink.

Structure
REQ-025 Shared package seg_pkg SHALL hold:
- NUM_DIGITS=4
- SEG_W=7
- SEG_BLANK=7'b0000000
- The digit-index width constant.
REQ-026 The prescaler SHALL be a sub-module scan_tick_gen (parameter DIV; ports clk, rst, en, tick).

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Reset then en=1 with chars F,R,E,E:
- First frame (16 cycles): seg_out=0 while an cycles 0001,0010,0100,1000.
- Then one frame_start pulse.
- Next frame: seg_out[6:0]=1111001,1111001,1010000,1110001 for an=0001..1000.
REQ-028 Change char2 to 1111111 while idx=1:
- Display SHALL show the old char2 for the rest of the frame.
- The new value SHALL appear only after the next frame_start.
REQ-029 Drop en for 10 cycles while idx=2:
- an=0 and seg_out=0 one cycle later.
- On re-enable, digit 2 resumes with its remaining prescaler count, with no extra frame_start.
REQ-030 Assert rst while idx=3:
- All outputs 0 on the next cycle.
- idx restarts at 0, and shadows are blank until the next capture.
REQ-031 SEG_BLINK_EN defined, blink_mask=4'b0001, dp=4'b1000:
- Digit 0 blanks for frames 3-4 and shows for frames 5-6, periodically.
- Digit 3 seg_out[7]=1 throughout.
- Without the macro, digit 0 never blanks.
REQ-032 SCAN_DIV=1: idx SHALL advance every cycle and frame_start SHALL pulse every 4 cycles.
